// File: rtl/fp_i2f_cvt.sv
// Two-stage int32/uint32 -> binary32 converter with FMV.W.X passthrough.
// Define FP_I2F_RMM_EN to enable round-to-nearest-max-magnitude for rm=100.
module fp_i2f_cvt #(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_new_request,
    input  logic [ID_W-1:0] issue_id,
    output logic            issue_ready,
    input  logic [31:0]     rs1,
    input  logic [2:0]      rm,
    input  logic            fmv,
    input  logic            is_signed,
    output logic            wb_done,
    input  logic            wb_ack,
    output logic [ID_W-1:0] wb_id,
    output logic [31:0]     wb_rd,
    output logic [4:0]      fflags
);

    logic            adv1, adv2;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_sign_q, s1_sign_d;
    logic [31:0]     s1_mag_q, s1_mag_d;
    logic [4:0]      s1_lz_q, s1_lz_d;
    logic            s1_zero_q, s1_zero_d;
    logic [31:0]     s1_raw_q, s1_raw_d;
    logic [2:0]      s1_rm_q, s1_rm_d;
    logic            s1_fmv_q, s1_fmv_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;

    logic            wb_done_q, wb_done_d;
    logic [ID_W-1:0] wb_id_q, wb_id_d;
    logic [31:0]     wb_rd_q, wb_rd_d;
    logic [4:0]      fflags_q, fflags_d;

    assign adv2        = ~wb_done_q | wb_ack;
    assign adv1        = ~s1_valid_q | adv2;
    assign issue_ready = adv1;

    // Stage 1: sign/magnitude split and leading-zero count
    logic        sign_c;
    logic [31:0] mag_c;
    logic [4:0]  lz_c;

    always_comb begin
        sign_c = is_signed & rs1[31];
        mag_c  = sign_c ? (~rs1 + 32'd1) : rs1;
        lz_c   = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (mag_c[i]) lz_c = 5'(31 - i);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lz_d    = s1_lz_q;
        s1_zero_d  = s1_zero_q;
        s1_raw_d   = s1_raw_q;
        s1_rm_d    = s1_rm_q;
        s1_fmv_d   = s1_fmv_q;
        s1_id_d    = s1_id_q;
        if (adv1) begin
            s1_valid_d = issue_new_request;
            if (issue_new_request) begin
                s1_sign_d = sign_c;
                s1_mag_d  = mag_c;
                s1_lz_d   = lz_c;
                s1_zero_d = (mag_c == 32'd0);
                s1_raw_d  = rs1;
                s1_rm_d   = rm;
                s1_fmv_d  = fmv;
                s1_id_d   = issue_id;
            end
        end
    end

    // Stage 2: normalize, round, pack
    logic [30:0] norm_c;
    logic [7:0]  exp_c, exp_r_c;
    logic [22:0] mant_c;
    logic [23:0] mant_sum_c;
    logic        g_c, r_c, s_c, up_c;
    logic [31:0] res_c;
    logic [4:0]  flg_c;

    always_comb begin
        norm_c = 31'(s1_mag_q << s1_lz_q);
        exp_c  = 8'd158 - {3'b000, s1_lz_q};
        mant_c = norm_c[30:8];
        g_c    = norm_c[7];
        r_c    = norm_c[6];
        s_c    = |norm_c[5:0];
        case (s1_rm_q)
            3'b001:  up_c = 1'b0;
            3'b010:  up_c = s1_sign_q & (g_c | r_c | s_c);
            3'b011:  up_c = ~s1_sign_q & (g_c | r_c | s_c);
`ifdef FP_I2F_RMM_EN
            3'b100:  up_c = g_c;
`endif
            default: up_c = g_c & (r_c | s_c | mant_c[0]);
        endcase
        // A carry out of the mantissa leaves it zero and bumps the exponent
        mant_sum_c = {1'b0, mant_c} + {23'd0, up_c};
        exp_r_c    = exp_c + {7'd0, mant_sum_c[23]};
        res_c      = 32'd0;
        flg_c      = 5'd0;
        if (s1_fmv_q) begin
            res_c = s1_raw_q;
        end else if (!s1_zero_q) begin
            res_c = {s1_sign_q, exp_r_c, mant_sum_c[22:0]};
            flg_c = {4'd0, g_c | r_c | s_c};
        end
    end

    always_comb begin
        wb_done_d = wb_done_q;
        wb_id_d   = wb_id_q;
        wb_rd_d   = wb_rd_q;
        fflags_d  = fflags_q;
        if (adv2) begin
            wb_done_d = s1_valid_q;
            if (s1_valid_q) begin
                wb_id_d  = s1_id_q;
                wb_rd_d  = res_c;
                fflags_d = flg_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= 32'd0;
            s1_lz_q    <= 5'd0;
            s1_zero_q  <= 1'b0;
            s1_raw_q   <= 32'd0;
            s1_rm_q    <= 3'd0;
            s1_fmv_q   <= 1'b0;
            s1_id_q    <= '0;
            wb_done_q  <= 1'b0;
            wb_id_q    <= '0;
            wb_rd_q    <= 32'd0;
            fflags_q   <= 5'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_lz_q    <= s1_lz_d;
            s1_zero_q  <= s1_zero_d;
            s1_raw_q   <= s1_raw_d;
            s1_rm_q    <= s1_rm_d;
            s1_fmv_q   <= s1_fmv_d;
            s1_id_q    <= s1_id_d;
            wb_done_q  <= wb_done_d;
            wb_id_q    <= wb_id_d;
            wb_rd_q    <= wb_rd_d;
            fflags_q   <= fflags_d;
        end
    end

    assign wb_done = wb_done_q;
    assign wb_id   = wb_id_q;
    assign wb_rd   = wb_rd_q;
    assign fflags  = fflags_q;

endmodule

// File: tb/tb_fp_i2f_cvt.sv
// Self-checking bench for fp_i2f_cvt: directed vectors, backpressure,
// reset flush and a reference-model random sweep via a scoreboard queue.
module tb_fp_i2f_cvt;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_new_request;
    logic [2:0]  issue_id;
    logic        issue_ready;
    logic [31:0] rs1;
    logic [2:0]  rm;
    logic        fmv;
    logic        is_signed;
    logic        wb_done;
    logic        wb_ack;
    logic [2:0]  wb_id;
    logic [31:0] wb_rd;
    logic [4:0]  fflags;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] rd;
        logic [4:0]  fl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0] id_cnt = 3'd0;

    always #5 clk = ~clk;

    fp_i2f_cvt #(.ID_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_new_request(issue_new_request), .issue_id(issue_id),
        .issue_ready(issue_ready), .rs1(rs1), .rm(rm), .fmv(fmv),
        .is_signed(is_signed), .wb_done(wb_done), .wb_ack(wb_ack),
        .wb_id(wb_id), .wb_rd(wb_rd), .fflags(fflags)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact shift-and-remainder rounding, returns {flags, result}
    function automatic logic [36:0] model(input logic [31:0] r,
        input logic [2:0] m, input logic f, input logic s);
        logic        sg;
        logic [31:0] mag, trunc, rem, half;
        int          p, sh;
        logic        up;
        logic [7:0]  e;
        if (f) return {5'd0, r};
        sg  = s & r[31];
        mag = sg ? (32'd0 - r) : r;
        if (mag == 0) return 37'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        e = 8'(127 + p);
        if (p <= 23) return {5'd0, sg, e, 23'(mag << (23 - p))};
        sh    = p - 23;
        trunc = mag >> sh;
        rem   = mag & ((32'd1 << sh) - 32'd1);
        half  = 32'd1 << (sh - 1);
        case (m)
            3'b001: up = 1'b0;
            3'b010: up = sg && rem != 0;
            3'b011: up = !sg && rem != 0;
`ifdef FP_I2F_RMM_EN
            3'b100: up = rem >= half;
`endif
            default: up = (rem > half) || (rem == half && trunc[0]);
        endcase
        trunc = trunc + {31'd0, up};
        if (trunc[24]) begin
            trunc = trunc >> 1;
            e     = e + 8'd1;
        end
        return {4'd0, rem != 0, sg, e, trunc[22:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && wb_done && wb_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_rd", wb_rd, e.rd);
                check("wb_id", {29'd0, wb_id}, {29'd0, e.id});
                check("fflags", {27'd0, fflags}, {27'd0, e.fl});
            end
        end
    end

    // Drive one request until accepted; expectation pushed on acceptance
    task automatic send(input logic [31:0] r, input logic [2:0] m,
                        input logic f, input logic s,
                        input logic [31:0] erd, input logic [4:0] efl);
        bit ok = 0;
        issue_new_request = 1'b1;
        rs1 = r; rm = m; fmv = f; is_signed = s; issue_id = id_cnt;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (issue_ready) begin
                sb.push_back('{id: id_cnt, rd: erd, fl: efl});
                id_cnt = id_cnt + 3'd1;
                ok = 1;
            end
            @(posedge clk); #1;
        end
        if (!ok) check("issue_timeout", 32'd1, 32'd0);
        issue_new_request = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] r, input logic [2:0] m,
                          input logic f, input logic s);
        logic [36:0] x;
        x = model(r, m, f, s);
        send(r, m, f, s, x[31:0], x[36:32]);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", sb.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] rmm_exp;
        int acc;
        rst = 1'b1; issue_new_request = 1'b0; issue_id = 3'd0;
        rs1 = 32'd0; rm = 3'd0; fmv = 1'b0; is_signed = 1'b0;
        wb_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_done", {31'd0, wb_done}, 32'd0);
        check("rst_wb_id", {29'd0, wb_id}, 32'd0);
        check("rst_wb_rd", wb_rd, 32'd0);
        check("rst_fflags", {27'd0, fflags}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, issue_ready}, 32'd1);
        @(posedge clk); #1;

        // Latency: 2 cycles from issue to wb_done
        send(32'd1, 3'b000, 1'b0, 1'b1, 32'h3F800000, 5'd0);
        @(negedge clk);
        check("lat_cycle1", {31'd0, wb_done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_cycle2", {31'd0, wb_done}, 32'd1);
        @(posedge clk); #1;
        drain();

        rmm_exp = 32'h4B800000;
`ifdef FP_I2F_RMM_EN
        rmm_exp = 32'h4B800001;
`endif
        send(32'hFFFFFFFF, 3'b000, 1'b0, 1'b1, 32'hBF800000, 5'd0);
        send(32'h7FFFFFFF, 3'b000, 1'b0, 1'b1, 32'h4F000000, 5'd1);
        send(32'h7FFFFFFF, 3'b001, 1'b0, 1'b1, 32'h4EFFFFFF, 5'd1);
        send(32'h80000000, 3'b000, 1'b0, 1'b1, 32'hCF000000, 5'd0);
        send(32'hFFFFFFFF, 3'b000, 1'b0, 1'b0, 32'h4F800000, 5'd1);
        send(32'h00000000, 3'b000, 1'b0, 1'b0, 32'h00000000, 5'd0);
        send(32'h00000000, 3'b010, 1'b0, 1'b1, 32'h00000000, 5'd0);
        send(32'h01000001, 3'b100, 1'b0, 1'b1, rmm_exp, 5'd1);
        send(32'h7FC00001, 3'b011, 1'b1, 1'b1, 32'h7FC00001, 5'd0);
        send_m(32'hFEFFFFFF, 3'b010, 1'b0, 1'b1);
        send_m(32'hFEFFFFFF, 3'b011, 1'b0, 1'b1);
        send_m(32'h01000003, 3'b111, 1'b0, 1'b0);
        send_m(32'h01000001, 3'b011, 1'b0, 1'b0);
        drain();

        // Backpressure: 2 accepted, then stall 4 cycles
        wb_ack = 1'b0;
        send(32'd1, 3'b000, 1'b0, 1'b1, 32'h3F800000, 5'd0);
        send_m(32'd3, 3'b000, 1'b0, 1'b1);
        issue_new_request = 1'b1;
        rs1 = 32'hFFFFFFF9; rm = 3'b000; fmv = 1'b0; is_signed = 1'b1;
        issue_id = id_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_ready", {31'd0, issue_ready}, 32'd0);
            check("bp_done", {31'd0, wb_done}, 32'd1);
            check("bp_rd", wb_rd, 32'h3F800000);
            check("bp_id", {29'd0, wb_id}, {29'd0, id_cnt - 3'd2});
            check("bp_fl", {27'd0, fflags}, 32'd0);
            @(posedge clk); #1;
        end
        wb_ack = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {31'd0, issue_ready}, 32'd1);
        sb.push_back('{id: id_cnt, rd: 32'hC0E00000, fl: 5'd0});
        id_cnt = id_cnt + 3'd1;
        @(posedge clk); #1;
        issue_new_request = 1'b0;
        @(negedge clk);
        check("nobubble_1", {31'd0, wb_done}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("nobubble_2", {31'd0, wb_done}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Random sweep under random backpressure
        acc = 0;
        for (int k = 0; k < 400 && acc < 40; k++) begin
            logic [36:0] x;
            wb_ack = 1'($urandom);
            issue_new_request = 1'b1;
            rs1 = $urandom;
            if (k % 5 == 0) rs1 = rs1 >> $urandom_range(31, 0);
            rm = 3'($urandom_range(7, 0));
            fmv = ($urandom_range(9, 0) == 0);
            is_signed = 1'($urandom);
            issue_id = id_cnt;
            @(negedge clk);
            if (issue_ready) begin
                x = model(rs1, rm, fmv, is_signed);
                sb.push_back('{id: id_cnt, rd: x[31:0], fl: x[36:32]});
                id_cnt = id_cnt + 3'd1;
                acc++;
            end
            @(posedge clk); #1;
        end
        issue_new_request = 1'b0;
        wb_ack = 1'b1;
        check("rand_accepted", acc, 32'd40);
        drain();

        // Reset with both stages full discards everything
        wb_ack = 1'b0;
        send(32'd5, 3'b000, 1'b0, 1'b1, 32'h40A00000, 5'd0);
        send(32'd6, 3'b000, 1'b0, 1'b1, 32'h40C00000, 5'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        check("rst_flush_done", {31'd0, wb_done}, 32'd0);
        rst = 1'b0;
        wb_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, wb_done}, 32'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
